pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the CPU fetch stage, successor to the fixed 16-bit, step-by-2 counter. It adds configurable address width and instruction step, stall, PC-relative branch, absolute jump, call/return through an internal return-address stack (RAS), and a single-level trap/exception-return path with a saved EPC. It feeds instruction memory and receives control from the decode/control unit.

## Interface

Parameters:
- ADDR_WIDTH, 16, PC/address width in bits (≥ 4).
- STEP, 2, sequential increment in bytes; power of two, 1..8.
- RESET_VECTOR, 0, PC value after reset; must be STEP-aligned.
- TRAP_VECTOR, 16'h0100, PC loaded on trap; must be STEP-aligned.
- RAS_DEPTH, 4, return-stack entries; power of two, 2..16.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold all state this cycle.
- pc_op  in  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5 TRAP, 6 ERET, 7 reserved (treated as SEQ).
- target  in  ADDR_WIDTH  absolute target (JUMP/CALL/RET fallback) or signed two's-complement offset (BRANCH).
- pc_out  out  ADDR_WIDTH  current PC (registered).
- epc_out  out  ADDR_WIDTH  saved exception PC (registered).
- in_trap  out  1  trap handler active.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_err  out  1  one-cycle pulse: overflow or underflow.
- misaligned  out  1  one-cycle pulse: computed target had nonzero low bits.

## Operation

- Priority per cycle: reset > stall > pc_op.
- Reset: pc_out=RESET_VECTOR, epc_out=0, in_trap=0, RAS count=0, ras_empty=1, ras_full=0, ras_err=0, misaligned=0.
- stall=1: every register holds; ras_err and misaligned drive 0; pc_op ignored (no push/pop).
- SEQ: pc <= pc + STEP.
- BRANCH: pc <= pc + target (signed), modulo 2^ADDR_WIDTH.
- JUMP: pc <= target.
- CALL: push pc + STEP; pc <= target. If full: oldest entry overwritten (circular), count stays RAS_DEPTH, ras_err pulses.
- RET: non-empty → pc <= top entry, pop. Empty → pc <= target, count stays 0, ras_err pulses.
- TRAP: not in_trap → epc <= pc, in_trap <= 1, pc <= TRAP_VECTOR. Already in_trap → pc <= TRAP_VECTOR, epc unchanged (no nesting).
- ERET: in_trap → pc <= epc, in_trap <= 0. Not in_trap → behaves as SEQ.
- Alignment: for BRANCH/JUMP/CALL/RET, low log2(STEP) bits of the new PC forced to 0; misaligned pulses if any were 1 before masking. RAS entries and EPC are always aligned.
- All additions wrap modulo 2^ADDR_WIDTH; no carry out.
- RAS: circular buffer, write pointer plus saturating count (0..RAS_DEPTH); ras_empty = count==0, ras_full = count==RAS_DEPTH.

## Timing

- All outputs registered; effects of inputs sampled at edge N are visible after edge N.
- pc_out latency 1 cycle for every op; a pushed return address is poppable on the very next non-stalled cycle.
- ras_err/misaligned are high for exactly the one cycle following the offending edge; back-to-back faults give consecutive high cycles.
- Reset asserted mid-stream (during stall or any op) wins at that edge; RAS contents beyond count are don't-care.
- No combinational path from inputs to outputs.

## Test plan

- Reset then 4 SEQ (W=16, STEP=2) → pc_out 0x0000, 0x0002, 0x0004, 0x0006, 0x0008; wrap: pc 0xFFFE + SEQ → 0x0000.
- pc=0x0010, BRANCH target=0xFFF8 (−8) → 0x0008; JUMP target=0x0123 → pc 0x0122, misaligned pulse 1 cycle.
- pc=0x0020: CALL 0x0200, CALL 0x0300, RET, RET → 0x0200, 0x0300, 0x0202, 0x0022; ras_empty=1 at end.
- Five CALLs with RAS_DEPTH=4 → ras_full=1, ras_err on 5th; four RETs return newest four; fifth RET with target=0x0400 → pc 0x0400, ras_err pulse.
- pc=0x0044, TRAP → pc 0x0100, epc 0x0044, in_trap=1; TRAP again → epc still 0x0044; ERET → pc 0x0044, in_trap=0; ERET again → 0x0046.
- stall=1 for 3 cycles with pc_op=CALL → pc, RAS count unchanged; reset asserted during stall → pc 0x0000, ras_empty=1 next cycle.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter for the fetch stage.
// Supports sequential step, PC-relative branch, absolute jump, call/return through
// a circular return-address stack, and a single-level trap / exception return.
module pc_unit #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned STEP         = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(16'h0100),
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [2:0]            pc_op,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] epc_out,
  output logic                  in_trap,
  output logic                  ras_empty,
  output logic                  ras_full,
  output logic                  ras_err,
  output logic                  misaligned
);

  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] OP_SEQ    = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_TRAP   = 3'd5;
  localparam logic [2:0] OP_ERET   = 3'd6;

  // Low address bits that must be zero for a STEP-aligned PC.
  localparam logic [AW-1:0] LOW_MASK = AW'(STEP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [AW-1:0]    r_pc;
  logic [AW-1:0]    r_epc;
  logic             r_in_trap;
  logic [PTR_W-1:0] r_wp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ras_err;
  logic             r_misaligned;
  logic [AW-1:0]    r_ras [RAS_DEPTH];

  logic [AW-1:0]    w_pc_seq;
  logic [AW-1:0]    w_raw;
  logic             w_align;
  logic [AW-1:0]    w_pc_next;
  logic [AW-1:0]    w_epc_next;
  logic             w_trap_next;
  logic             w_push;
  logic             w_pop;
  logic             w_ras_err;
  logic             w_misaligned;
  logic             w_empty;
  logic             w_full;
  logic [PTR_W-1:0] w_top_idx;

  assign w_pc_seq  = r_pc + AW'(STEP);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_MAX);
  assign w_top_idx = r_wp - PTR_W'(1);

  // Next-state decode for PC, EPC, trap flag and RAS push/pop.
  always_comb begin
    w_raw        = w_pc_seq;
    w_align      = 1'b0;
    w_epc_next   = r_epc;
    w_trap_next  = r_in_trap;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_ras_err    = 1'b0;
    unique case (pc_op)
      OP_BRANCH: begin
        w_raw   = r_pc + target;
        w_align = 1'b1;
      end
      OP_JUMP: begin
        w_raw   = target;
        w_align = 1'b1;
      end
      OP_CALL: begin
        w_raw     = target;
        w_align   = 1'b1;
        w_push    = 1'b1;
        w_ras_err = w_full;
      end
      OP_RET: begin
        w_align = 1'b1;
        if (w_empty) begin
          w_raw     = target;
          w_ras_err = 1'b1;
        end else begin
          w_raw = r_ras[w_top_idx];
          w_pop = 1'b1;
        end
      end
      OP_TRAP: begin
        w_raw = TRAP_VECTOR;
        if (!r_in_trap) begin
          w_epc_next  = r_pc;
          w_trap_next = 1'b1;
        end
      end
      OP_ERET: begin
        if (r_in_trap) begin
          w_raw       = r_epc;
          w_trap_next = 1'b0;
        end
      end
      default: w_raw = w_pc_seq;
    endcase
    w_misaligned = w_align && ((w_raw & LOW_MASK) != '0);
    w_pc_next    = w_align ? (w_raw & ~LOW_MASK) : w_raw;
  end

  // Control registers: reset wins, stall holds and clears the fault pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_VECTOR;
      r_epc        <= '0;
      r_in_trap    <= 1'b0;
      r_wp         <= '0;
      r_cnt        <= '0;
      r_ras_err    <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (stall) begin
      r_ras_err    <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_pc         <= w_pc_next;
      r_epc        <= w_epc_next;
      r_in_trap    <= w_trap_next;
      r_ras_err    <= w_ras_err;
      r_misaligned <= w_misaligned;
      if (w_push) begin
        r_wp <= r_wp + PTR_W'(1);
        if (!w_full) r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_pop) begin
        r_wp  <= w_top_idx;
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Return-address storage; contents beyond the count are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (!reset && !stall && w_push) begin
      r_ras[r_wp] <= w_pc_seq;
    end
  end

  assign pc_out     = r_pc;
  assign epc_out    = r_epc;
  assign in_trap    = r_in_trap;
  assign ras_empty  = (r_cnt == '0);
  assign ras_full   = (r_cnt == CNT_MAX);
  assign ras_err    = r_ras_err;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  pc_op;
  logic [15:0] target;
  logic [15:0] pc_out;
  logic [15:0] epc_out;
  logic        in_trap;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;
  logic        misaligned;

  int tests;
  int fails;

  localparam logic [2:0] SEQ = 3'd0, BRANCH = 3'd1, JUMP = 3'd2, CALL = 3'd3,
                         RET = 3'd4, TRAP = 3'd5, ERET = 3'd6;

  pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .pc_op      (pc_op),
    .target     (target),
    .pc_out     (pc_out),
    .epc_out    (epc_out),
    .in_trap    (in_trap),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_err    (ras_err),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one operation across one rising edge, then settle past the edge.
  task automatic op(input logic [2:0] o, input logic [15:0] t);
    pc_op  = o;
    target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    reset  = 1'b1;
    stall  = 1'b0;
    pc_op  = SEQ;
    target = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_pc", pc_out, 16'h0000);
    check("rst_epc", epc_out, 16'h0000);
    check("rst_trap", in_trap, 1'b0);
    check("rst_empty", ras_empty, 1'b1);
    check("rst_full", ras_full, 1'b0);
    check("rst_err", ras_err, 1'b0);
    check("rst_mis", misaligned, 1'b0);

    // Sequential stepping and wrap.
    op(SEQ, 16'h0); check("seq1", pc_out, 16'h0002);
    op(SEQ, 16'h0); check("seq2", pc_out, 16'h0004);
    op(SEQ, 16'h0); check("seq3", pc_out, 16'h0006);
    op(SEQ, 16'h0); check("seq4", pc_out, 16'h0008);
    op(JUMP, 16'hFFFE); check("jmp_fffe", pc_out, 16'hFFFE);
    check("jmp_fffe_mis", misaligned, 1'b0);
    op(SEQ, 16'h0); check("seq_wrap", pc_out, 16'h0000);

    // Branch backward, misaligned jump.
    op(JUMP, 16'h0010); check("jmp_10", pc_out, 16'h0010);
    op(BRANCH, 16'hFFF8); check("br_neg8", pc_out, 16'h0008);
    check("br_mis", misaligned, 1'b0);
    op(JUMP, 16'h0123); check("jmp_mis_pc", pc_out, 16'h0122);
    check("jmp_mis_pulse", misaligned, 1'b1);
    op(SEQ, 16'h0); check("mis_clear", misaligned, 1'b0);
    check("seq_after_mis", pc_out, 16'h0124);

    // Nested call/return.
    op(JUMP, 16'h0020);
    op(CALL, 16'h0200); check("call1", pc_out, 16'h0200);
    check("call1_empty", ras_empty, 1'b0);
    op(CALL, 16'h0300); check("call2", pc_out, 16'h0300);
    op(RET, 16'h0); check("ret1", pc_out, 16'h0202);
    op(RET, 16'h0); check("ret2", pc_out, 16'h0022);
    check("ret2_empty", ras_empty, 1'b1);

    // Overflow and underflow.
    op(CALL, 16'h1000);
    op(CALL, 16'h2000);
    op(CALL, 16'h3000);
    op(CALL, 16'h4000); check("full4", ras_full, 1'b1);
    check("full4_err", ras_err, 1'b0);
    op(CALL, 16'h5000); check("ovf_err", ras_err, 1'b1);
    check("ovf_full", ras_full, 1'b1);
    check("ovf_pc", pc_out, 16'h5000);
    op(RET, 16'h0); check("ovr_ret1", pc_out, 16'h4002);
    check("ovr_err_clr", ras_err, 1'b0);
    check("ovr_full_clr", ras_full, 1'b0);
    op(RET, 16'h0); check("ovr_ret2", pc_out, 16'h3002);
    op(RET, 16'h0); check("ovr_ret3", pc_out, 16'h2002);
    op(RET, 16'h0); check("ovr_ret4", pc_out, 16'h1002);
    check("ovr_empty", ras_empty, 1'b1);
    op(RET, 16'h0400); check("unf_pc", pc_out, 16'h0400);
    check("unf_err", ras_err, 1'b1);
    check("unf_empty", ras_empty, 1'b1);
    op(SEQ, 16'h0); check("unf_err_clr", ras_err, 1'b0);
    check("unf_seq", pc_out, 16'h0402);

    // Trap / exception return.
    op(JUMP, 16'h0044);
    op(TRAP, 16'h0); check("trap_pc", pc_out, 16'h0100);
    check("trap_epc", epc_out, 16'h0044);
    check("trap_flag", in_trap, 1'b1);
    op(SEQ, 16'h0); check("handler_seq", pc_out, 16'h0102);
    op(TRAP, 16'h0); check("trap2_pc", pc_out, 16'h0100);
    check("trap2_epc", epc_out, 16'h0044);
    op(ERET, 16'h0); check("eret_pc", pc_out, 16'h0044);
    check("eret_flag", in_trap, 1'b0);
    op(ERET, 16'h0); check("eret2_pc", pc_out, 16'h0046);

    // Stall holds everything, ignoring CALL and misaligned targets.
    op(CALL, 16'h0500); check("pre_stall_pc", pc_out, 16'h0500);
    stall = 1'b1;
    op(CALL, 16'h0601); check("stall1_pc", pc_out, 16'h0500);
    check("stall1_mis", misaligned, 1'b0);
    op(CALL, 16'h0601);
    op(CALL, 16'h0601); check("stall3_pc", pc_out, 16'h0500);
    check("stall3_empty", ras_empty, 1'b0);
    check("stall3_err", ras_err, 1'b0);
    stall = 1'b0;
    op(RET, 16'h0); check("stall_ret", pc_out, 16'h0048);
    check("stall_ret_empty", ras_empty, 1'b1);

    // Reset during stall wins.
    op(CALL, 16'h0700);
    op(TRAP, 16'h0); check("pre_rst_trap", in_trap, 1'b1);
    stall = 1'b1;
    reset = 1'b1;
    op(CALL, 16'h0800);
    reset = 1'b0;
    stall = 1'b0;
    check("rst_stall_pc", pc_out, 16'h0000);
    check("rst_stall_empty", ras_empty, 1'b1);
    check("rst_stall_trap", in_trap, 1'b0);
    check("rst_stall_epc", epc_out, 16'h0000);
    op(SEQ, 16'h0); check("post_rst_seq", pc_out, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
